// File: rtl/message_retransmitter.sv
// Reliable-send controller: tags each message with an alternating sequence bit and resends it on timeout until acked or retries run out.
// Optional `RETX_STATS_EN adds a saturating resend counter output retx_total.
module message_retransmitter #(
    parameter int DATA_WIDTH  = 8,
    parameter int MAX_RETRIES = 3
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] msg_data,
    input  logic                  msg_valid,
    output logic                  msg_ready,
    output logic [DATA_WIDTH-1:0] tx_data,
    output logic                  tx_seq,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    input  logic                  ack_valid,
    input  logic                  ack_seq,
    input  logic                  timer_irq,
    output logic                  timer_reset,
    output logic                  busy,
    output logic                  done,
    output logic                  fail,
`ifdef RETX_STATS_EN
    output logic [15:0]           retx_total,
`endif
    output logic [1:0]            state_dbg
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both
    // high; valid never waits on ready, and payload stays stable while valid is held.
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SEND     = 2'd1,
        WAIT_ACK = 2'd2
    } state_e;

    localparam logic [3:0] MAX_CNT = 4'(MAX_RETRIES);

    state_e     state;
    state_e     state_next;
    logic       seq;
    logic [3:0] retry_cnt;

    logic accept;
    logic ack_hit;
    logic retry;
    logic give_up;

    // An ack that matches the current sequence bit beats a same-cycle timeout.
    assign accept  = (state == IDLE) && msg_valid;
    assign ack_hit = (state == WAIT_ACK) && ack_valid && (ack_seq == seq);
    assign retry   = (state == WAIT_ACK) && !ack_hit && timer_irq && (retry_cnt != MAX_CNT);
    assign give_up = (state == WAIT_ACK) && !ack_hit && timer_irq && (retry_cnt == MAX_CNT);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) state_next = SEND;
            end
            SEND: begin
                if (tx_ready) state_next = WAIT_ACK;
            end
            WAIT_ACK: begin
                if (ack_hit || give_up) state_next = IDLE;
                else if (retry)         state_next = SEND;
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        msg_ready   = 1'b0;
        tx_valid    = 1'b0;
        busy        = 1'b1;
        timer_reset = 1'b1;
        case (state)
            IDLE: begin
                msg_ready = 1'b1;
                busy      = 1'b0;
            end
            SEND:     tx_valid    = 1'b1;
            WAIT_ACK: timer_reset = 1'b0;
            default: begin
                msg_ready = 1'b0;
                busy      = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            seq       <= 1'b0;
            retry_cnt <= 4'd0;
            tx_data   <= '0;
            done      <= 1'b0;
            fail      <= 1'b0;
        end else begin
            done <= ack_hit;
            fail <= give_up;
            if (accept) begin
                tx_data   <= msg_data;
                retry_cnt <= 4'd0;
            end else if (retry) begin
                retry_cnt <= retry_cnt + 4'd1;
            end
            // The sequence bit advances once per message, whether delivered or dropped.
            if (ack_hit || give_up) seq <= ~seq;
        end
    end

`ifdef RETX_STATS_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            retx_total <= 16'd0;
        end else if (retry && (retx_total != 16'hFFFF)) begin
            retx_total <= retx_total + 16'd1;
        end
    end
`endif

    assign tx_seq    = seq;
    assign state_dbg = state;

endmodule

// File: tb/tb_message_retransmitter.sv
// Self-checking bench for message_retransmitter: directed scenarios plus a send scoreboard.
module tb_message_retransmitter;

    logic       clock;
    logic       reset;
    logic [7:0] msg_data;
    logic       msg_valid;
    logic       msg_ready;
    logic [7:0] tx_data;
    logic       tx_seq;
    logic       tx_valid;
    logic       tx_ready;
    logic       ack_valid;
    logic       ack_seq;
    logic       timer_irq;
    logic       timer_reset;
    logic       busy;
    logic       done;
    logic       fail;
    logic [1:0] state_dbg;
`ifdef RETX_STATS_EN
    logic [15:0] retx_total;
`endif

    logic [8:0] exp_q[$];
    logic [8:0] obs_q[$];
    int         vectors;
    int         miscompares;
    logic       seq_m;
    int         retx_m;

    message_retransmitter #(.DATA_WIDTH(8), .MAX_RETRIES(3)) dut (
        .clock       (clock),
        .reset       (reset),
        .msg_data    (msg_data),
        .msg_valid   (msg_valid),
        .msg_ready   (msg_ready),
        .tx_data     (tx_data),
        .tx_seq      (tx_seq),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .ack_valid   (ack_valid),
        .ack_seq     (ack_seq),
        .timer_irq   (timer_irq),
        .timer_reset (timer_reset),
        .busy        (busy),
        .done        (done),
        .fail        (fail),
`ifdef RETX_STATS_EN
        .retx_total  (retx_total),
`endif
        .state_dbg   (state_dbg)
    );

    // clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    // record every accepted send on the link
    always @(negedge clock) begin
        if (reset && tx_valid && tx_ready) obs_q.push_back({tx_seq, tx_data});
    end

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    // drivers
    task automatic accept_msg(input logic [7:0] d);
        int n;
        n = 0;
        while (!msg_ready && n < 20) begin
            tick;
            n++;
        end
        vectors++;
        if (msg_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL msg_ready_wait: got %b, required 1", msg_ready);
        end
        msg_data  = d;
        msg_valid = 1'b1;
        exp_q.push_back({seq_m, d});
        tick;
        msg_valid = 1'b0;
        msg_data  = 8'h00;
        vectors++;
        if (tx_valid !== 1'b1 || tx_data !== d || tx_seq !== seq_m) begin
            miscompares++;
            $display("FAIL first_send: got v=%b d=%h s=%b, required v=1 d=%h s=%b",
                     tx_valid, tx_data, tx_seq, d, seq_m);
        end
    endtask

    task automatic to_wait;
        tick;
        vectors++;
        if (timer_reset !== 1'b0 || busy !== 1'b1 || tx_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL wait_ack_entry: got tr=%b busy=%b v=%b, required tr=0 busy=1 v=0",
                     timer_reset, busy, tx_valid);
        end
    endtask

    task automatic test_reset;
        reset = 1'b0;
        #12;
        vectors++;
        if (msg_ready !== 1'b1 || tx_valid !== 1'b0 || timer_reset !== 1'b1 || busy !== 1'b0 ||
            done !== 1'b0 || fail !== 1'b0 || tx_data !== 8'h00 || tx_seq !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_state: got rdy=%b v=%b tr=%b busy=%b done=%b fail=%b d=%h s=%b, required 1 0 1 0 0 0 00 0",
                     msg_ready, tx_valid, timer_reset, busy, done, fail, tx_data, tx_seq);
        end
`ifdef RETX_STATS_EN
        vectors++;
        if (retx_total !== 16'd0) begin
            miscompares++;
            $display("FAIL reset_retx: got %0d, required 0", retx_total);
        end
`endif
        @(posedge clock);
        #3;
        reset = 1'b1;
        tick;
    endtask

    task automatic test_single_ack;
        accept_msg(8'hA5);
        to_wait;
        tick;
        ack_valid = 1'b1;
        ack_seq   = seq_m;
        tick;
        ack_valid = 1'b0;
        seq_m     = ~seq_m;
        vectors++;
        if (done !== 1'b1 || fail !== 1'b0 || busy !== 1'b0 || tx_seq !== seq_m || msg_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL ack_done: got done=%b fail=%b busy=%b s=%b rdy=%b, required 1 0 0 %b 1",
                     done, fail, busy, tx_seq, msg_ready, seq_m);
        end
        tick;
        vectors++;
        if (done !== 1'b0) begin
            miscompares++;
            $display("FAIL done_pulse_width: got %b, required 0", done);
        end
    endtask

    task automatic test_one_retry;
        accept_msg(8'h3C);
        to_wait;
        tick;
        tick;
        timer_irq = 1'b1;
        exp_q.push_back({seq_m, 8'h3C});
        retx_m++;
        tick;
        timer_irq = 1'b0;
        vectors++;
        if (tx_valid !== 1'b1 || tx_data !== 8'h3C || tx_seq !== seq_m || timer_reset !== 1'b1) begin
            miscompares++;
            $display("FAIL resend: got v=%b d=%h s=%b tr=%b, required 1 3c %b 1",
                     tx_valid, tx_data, tx_seq, timer_reset, seq_m);
        end
        to_wait;
        ack_valid = 1'b1;
        ack_seq   = seq_m;
        tick;
        ack_valid = 1'b0;
        seq_m     = ~seq_m;
        vectors++;
        if (done !== 1'b1 || fail !== 1'b0) begin
            miscompares++;
            $display("FAIL retry_done: got done=%b fail=%b, required 1 0", done, fail);
        end
`ifdef RETX_STATS_EN
        vectors++;
        if (retx_total !== 16'(retx_m)) begin
            miscompares++;
            $display("FAIL retx_total: got %0d, required %0d", retx_total, retx_m);
        end
`endif
    endtask

    task automatic test_exhaust;
        accept_msg(8'h5A);
        for (int i = 0; i < 4; i++) begin
            to_wait;
            tick;
            timer_irq = 1'b1;
            if (i < 3) begin
                exp_q.push_back({seq_m, 8'h5A});
                retx_m++;
            end
            tick;
            timer_irq = 1'b0;
            vectors++;
            if (i < 3) begin
                if (tx_valid !== 1'b1 || fail !== 1'b0 || done !== 1'b0) begin
                    miscompares++;
                    $display("FAIL exhaust_resend_%0d: got v=%b fail=%b done=%b, required 1 0 0",
                             i, tx_valid, fail, done);
                end
            end else begin
                seq_m = ~seq_m;
                if (fail !== 1'b1 || done !== 1'b0 || busy !== 1'b0 || tx_seq !== seq_m) begin
                    miscompares++;
                    $display("FAIL exhaust_fail: got fail=%b done=%b busy=%b s=%b, required 1 0 0 %b",
                             fail, done, busy, tx_seq, seq_m);
                end
            end
        end
        tick;
        vectors++;
        if (fail !== 1'b0 || tx_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL fail_pulse_width: got fail=%b v=%b, required 0 0", fail, tx_valid);
        end
    endtask

    task automatic test_ack_rules;
        ack_valid = 1'b1;
        ack_seq   = seq_m;
        timer_irq = 1'b1;
        tick;
        ack_valid = 1'b0;
        timer_irq = 1'b0;
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0 || fail !== 1'b0 || tx_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL idle_ignore: got busy=%b done=%b fail=%b v=%b, required 0 0 0 0",
                     busy, done, fail, tx_valid);
        end
        accept_msg(8'h77);
        to_wait;
        ack_valid = 1'b1;
        ack_seq   = ~seq_m;
        tick;
        ack_valid = 1'b0;
        vectors++;
        if (done !== 1'b0 || busy !== 1'b1 || timer_reset !== 1'b0) begin
            miscompares++;
            $display("FAIL stale_ack: got done=%b busy=%b tr=%b, required 0 1 0", done, busy, timer_reset);
        end
        ack_valid = 1'b1;
        ack_seq   = seq_m;
        timer_irq = 1'b1;
        tick;
        ack_valid = 1'b0;
        timer_irq = 1'b0;
        seq_m     = ~seq_m;
        vectors++;
        if (done !== 1'b1 || fail !== 1'b0 || tx_valid !== 1'b0 || msg_ready !== 1'b1 || tx_seq !== seq_m) begin
            miscompares++;
            $display("FAIL ack_beats_irq: got done=%b fail=%b v=%b rdy=%b s=%b, required 1 0 0 1 %b",
                     done, fail, tx_valid, msg_ready, tx_seq, seq_m);
        end
    endtask

    task automatic test_backpressure;
        tx_ready = 1'b0;
        accept_msg(8'hC3);
        for (int i = 0; i < 10; i++) begin
            tick;
            vectors++;
            if (tx_valid !== 1'b1 || tx_data !== 8'hC3 || tx_seq !== seq_m || timer_reset !== 1'b1) begin
                miscompares++;
                $display("FAIL backpressure_%0d: got v=%b d=%h s=%b tr=%b, required 1 c3 %b 1",
                         i, tx_valid, tx_data, tx_seq, timer_reset, seq_m);
            end
        end
        tx_ready = 1'b1;
        to_wait;
        ack_valid = 1'b1;
        ack_seq   = seq_m;
        tick;
        ack_valid = 1'b0;
        seq_m     = ~seq_m;
        vectors++;
        if (done !== 1'b1) begin
            miscompares++;
            $display("FAIL backpressure_done: got %b, required 1", done);
        end
    endtask

    task automatic test_reset_midflight;
        accept_msg(8'h99);
        to_wait;
        tick;
        #2;
        reset = 1'b0;
        #1;
        seq_m  = 1'b0;
        retx_m = 0;
        vectors++;
        if (tx_valid !== 1'b0 || timer_reset !== 1'b1 || tx_seq !== 1'b0 || busy !== 1'b0 || msg_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL async_reset: got v=%b tr=%b s=%b busy=%b rdy=%b, required 0 1 0 0 1",
                     tx_valid, timer_reset, tx_seq, busy, msg_ready);
        end
`ifdef RETX_STATS_EN
        vectors++;
        if (retx_total !== 16'd0) begin
            miscompares++;
            $display("FAIL async_reset_retx: got %0d, required 0", retx_total);
        end
`endif
        @(posedge clock);
        #3;
        reset = 1'b1;
        tick;
    endtask

    task automatic test_back_to_back;
        logic [7:0] d;
        int         nirq;
        for (int m = 0; m < 6; m++) begin
            d    = 8'($urandom_range(0, 255));
            nirq = $urandom_range(0, 3);
            accept_msg(d);
            for (int r = 0; r < nirq; r++) begin
                to_wait;
                timer_irq = 1'b1;
                exp_q.push_back({seq_m, d});
                retx_m++;
                tick;
                timer_irq = 1'b0;
            end
            to_wait;
            ack_valid = 1'b1;
            ack_seq   = seq_m;
            tick;
            ack_valid = 1'b0;
            seq_m     = ~seq_m;
            vectors++;
            if (done !== 1'b1 || fail !== 1'b0 || tx_seq !== seq_m) begin
                miscompares++;
                $display("FAIL b2b_%0d: got done=%b fail=%b s=%b, required 1 0 %b", m, done, fail, tx_seq, seq_m);
            end
        end
`ifdef RETX_STATS_EN
        vectors++;
        if (retx_total !== 16'(retx_m)) begin
            miscompares++;
            $display("FAIL b2b_retx_total: got %0d, required %0d", retx_total, retx_m);
        end
`endif
    endtask

    // scoreboard: every expected send against the recorded link traffic, in order
    task automatic test_scoreboard;
        logic [8:0] e;
        logic [8:0] o;
        vectors++;
        if (obs_q.size() != exp_q.size()) begin
            miscompares++;
            $display("FAIL send_count: got %0d, required %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL send_payload: got seq=%b data=%h, required seq=%b data=%h", o[8], o[7:0], e[8], e[7:0]);
            end
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        seq_m       = 1'b0;
        retx_m      = 0;
        msg_data    = 8'h00;
        msg_valid   = 1'b0;
        tx_ready    = 1'b1;
        ack_valid   = 1'b0;
        ack_seq     = 1'b0;
        timer_irq   = 1'b0;
        test_reset;
        test_single_ack;
        test_one_retry;
        test_exhaust;
        test_ack_rules;
        test_backpressure;
        test_reset_midflight;
        test_back_to_back;
        tick;
        test_scoreboard;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
